pre_i_ctrl: RTL and testbench

//  Sequencer for the pre-intra DC/planar decision datapath. On a start handshake it walks one 32x32 LCU
//  as sixteen 8x8 blocks. Per block it generates blockcnt, cnt and the counterrun1/counterrun2 gradient

---
 rtl/pre_i_pkg.sv | 26 ++
 rtl/pre_i_ctrl_if.sv | 35 +++
 rtl/pre_i_strobe_dec.sv | 33 +++
 rtl/pre_i_ctrl.sv | 108 ++++++++++
 tb/tb_pre_i_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pre_i_pkg.sv
// Shared types and constants for the pre-intra DC/planar sequencer.
// Holds the FSM encoding, counter widths and strobe cycle indices.
package pre_i_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CNT_W      = 6;
  localparam int BLK_W      = 7;
  localparam int CNT_BM8    = 36;
  localparam int CNT_BM16   = 39;
  localparam int CNT_BM32   = 40;
  localparam int CNT_LATCH8 = 7;

  typedef struct packed {
    logic counterrun1;
    logic counterrun2;
    logic bm8_vld;
    logic bm16_vld;
    logic bm32_vld;
  } strobe_t;

endpackage

// File: rtl/pre_i_ctrl_if.sv
// Control/status bundle between the pre-intra sequencer and its user.
// master drives start/hold; slave (the sequencer) drives the rest.
interface pre_i_ctrl_if;
  import pre_i_pkg::*;

  logic             start;
  logic             hold;
  logic             ready;
  logic             busy;
  logic             done;
  logic             counterrun1;
  logic             counterrun2;
  logic [CNT_W-1:0] cnt;
  logic [BLK_W-1:0] blockcnt;
  logic             bm8_vld;
  logic             bm16_vld;
  logic             bm32_vld;

  modport master (
    output start, hold,
    input  ready, busy, done,
    input  counterrun1, counterrun2,
    input  cnt, blockcnt,
    input  bm8_vld, bm16_vld, bm32_vld
  );

  modport slave (
    input  start, hold,
    output ready, busy, done,
    output counterrun1, counterrun2,
    output cnt, blockcnt,
    output bm8_vld, bm16_vld, bm32_vld
  );

endinterface

// File: rtl/pre_i_strobe_dec.sv
// Pure decode of sequencer state/counters into datapath windows
// and best-mode valid strobes; hold (if enabled upstream) masks all.
module pre_i_strobe_dec #(
  parameter int GRAD_LEN = 6,
  parameter int NBLK     = 16
) (
  input  pre_i_pkg::state_e             state,
  input  logic [pre_i_pkg::CNT_W-1:0]   cnt,
  input  logic [pre_i_pkg::BLK_W-1:0]   blockcnt,
  input  logic                          hold,
  output pre_i_pkg::strobe_t            strb
);
  import pre_i_pkg::*;

  logic act;

  assign act = (state == RUN) && !hold;

  always_comb begin
    strb = '0;
    if (act) begin
      strb.counterrun1 = cnt <= CNT_W'(GRAD_LEN - 1);
      strb.counterrun2 = (cnt >= CNT_W'(1))
                      && (cnt <= CNT_W'(GRAD_LEN));
      strb.bm8_vld     = cnt == CNT_W'(CNT_BM8);
      strb.bm16_vld    = (cnt == CNT_W'(CNT_BM16))
                      && (blockcnt[1:0] == 2'b00);
      strb.bm32_vld    = (cnt == CNT_W'(CNT_BM32))
                      && (blockcnt == BLK_W'(NBLK));
    end
  end

endmodule

// File: rtl/pre_i_ctrl.sv
// Pre-intra LCU sequencer: walks sixteen 8x8 blocks of 41 cycles each.
// Optional freeze input enabled by defining PRE_I_CTRL_HOLD_EN.
module pre_i_ctrl #(
  parameter int CNT_MAX  = 40,
  parameter int GRAD_LEN = 6,
  parameter int NBLK     = 16
) (
  input logic         clk,
  input logic         rstn,
  pre_i_ctrl_if.slave bus
);
  import pre_i_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             hold_act;
  logic             last_cnt;
  logic             last_blk;
  strobe_t          strb;

`ifdef PRE_I_CTRL_HOLD_EN
  assign hold_act = bus.hold;
`else
  logic unused_hold;
  assign unused_hold = bus.hold;
  assign hold_act    = 1'b0;
`endif

  assign last_cnt = cnt_q == CNT_W'(CNT_MAX);
  assign last_blk = blk_q == BLK_W'(NBLK);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (!hold_act && last_cnt && last_blk)
                 state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters park at zero outside RUN so blockcnt reads 0 when idle.
  always_comb begin
    cnt_d = cnt_q;
    blk_d = blk_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d = '0;
          blk_d = BLK_W'(1);
        end
      end
      RUN: begin
        if (!hold_act) begin
          if (last_cnt) begin
            cnt_d = '0;
            blk_d = last_blk ? '0 : blk_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        cnt_d = '0;
        blk_d = '0;
      end
    endcase
  end

  pre_i_strobe_dec #(
    .GRAD_LEN (GRAD_LEN),
    .NBLK     (NBLK)
  ) u_dec (
    .state    (state_q),
    .cnt      (cnt_q),
    .blockcnt (blk_q),
    .hold     (hold_act),
    .strb     (strb)
  );

  always_comb begin
    bus.ready       = state_q == IDLE;
    bus.busy        = state_q == RUN;
    bus.done        = state_q == DONE;
    bus.cnt         = cnt_q;
    bus.blockcnt    = blk_q;
    bus.counterrun1 = strb.counterrun1;
    bus.counterrun2 = strb.counterrun2;
    bus.bm8_vld     = strb.bm8_vld;
    bus.bm16_vld    = strb.bm16_vld;
    bus.bm32_vld    = strb.bm32_vld;
  end

endmodule

// File: tb/tb_pre_i_ctrl.sv
// Scoreboard bench for pre_i_ctrl: LCU-step reference model feeds a
// queue of expected outputs that a negedge monitor pops and compares.
module tb_pre_i_ctrl;

`ifdef PRE_I_CTRL_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  localparam int CNT_MAX  = 40;
  localparam int GRAD_LEN = 6;
  localparam int NBLK     = 16;
  localparam int BLEN     = CNT_MAX + 1;
  localparam int STEPS    = NBLK * BLEN;

  typedef struct {
    bit ready, busy, done, cr1, cr2, b8, b16, b32;
    int cnt, blk;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pre_i_ctrl_if bus ();

  pre_i_ctrl #(
    .CNT_MAX  (CNT_MAX),
    .GRAD_LEN (GRAD_LEN),
    .NBLK     (NBLK)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_done = 0, n_runs = 0, n8 = 0, n16 = 0, n32 = 0;
  int t_run = 0, t_done = 0;
  bit prev_busy = 1'b0;

  exp_t q[$];

  // Model: 0 idle, 1 run (step k of the LCU), 2 done.
  int m_st = 0;
  int m_k  = 0;

  function automatic exp_t m_out(bit gate);
    exp_t e;
    int c, b;
    bit act;
    c = (m_st == 1) ? m_k % BLEN : 0;
    b = (m_st == 1) ? m_k / BLEN + 1 : 0;
    act = (m_st == 1) && !gate;
    e.ready = m_st == 0;
    e.busy  = m_st == 1;
    e.done  = m_st == 2;
    e.cnt   = c;
    e.blk   = b;
    e.cr1   = act && c < GRAD_LEN;
    e.cr2   = act && c >= 1 && c <= GRAD_LEN;
    e.b8    = act && c == 36;
    e.b16   = act && c == 39 && (b % 4) == 0;
    e.b32   = act && c == 40 && b == NBLK;
    return e;
  endfunction

  always @(posedge clk) begin
    bit gate;
    gate = HOLD_EN && bus.hold;
    if (!rstn) begin
      m_st = 0;
      m_k  = 0;
    end else begin
      case (m_st)
        0: if (bus.start) begin m_st = 1; m_k = 0; end
        1: if (!gate) begin
             if (m_k == STEPS - 1) m_st = 2;
             else m_k++;
           end
        default: m_st = 0;
      endcase
    end
    q.push_back(m_out(gate));
  end

  always @(negedge clk) begin
    exp_t e;
    bit ok;
    cyc++;
    if (q.size() != 0) begin
      e = q.pop_front();
      vectors++;
      ok = (bus.ready == e.ready) && (bus.busy == e.busy)
        && (bus.done == e.done) && (int'(bus.cnt) == e.cnt)
        && (int'(bus.blockcnt) == e.blk)
        && (bus.counterrun1 == e.cr1) && (bus.counterrun2 == e.cr2)
        && (bus.bm8_vld == e.b8) && (bus.bm16_vld == e.b16)
        && (bus.bm32_vld == e.b32);
      if (!ok) begin
        miscompares++;
        $display("FAIL outputs cyc %0d: got r%0b b%0b d%0b cnt%0d blk%0d cr%0b%0b bm%0b%0b%0b, expected r%0b b%0b d%0b cnt%0d blk%0d cr%0b%0b bm%0b%0b%0b",
          cyc, bus.ready, bus.busy, bus.done, bus.cnt, bus.blockcnt,
          bus.counterrun1, bus.counterrun2,
          bus.bm8_vld, bus.bm16_vld, bus.bm32_vld,
          e.ready, e.busy, e.done, e.cnt, e.blk, e.cr1, e.cr2,
          e.b8, e.b16, e.b32);
      end
    end
    if (bus.done) begin n_done++; t_done = cyc; end
    if (bus.busy && !prev_busy) begin n_runs++; t_run = cyc; end
    if (bus.bm8_vld)  n8++;
    if (bus.bm16_vld) n16++;
    if (bus.bm32_vld) n32++;
    prev_busy = bus.busy;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr();
    n_done = 0; n_runs = 0; n8 = 0; n16 = 0; n32 = 0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int d0;
    int i;
    d0 = n_done;
    i = 0;
    while (n_done == d0 && i < budget) begin tick(); i++; end
    if (n_done == d0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_ready(int budget);
    int i;
    i = 0;
    while (!bus.ready && i < budget) begin tick(); i++; end
    chk("ready_wait", int'(bus.ready), 1);
  endtask

  task automatic wait_pos(int blk, int c, int budget);
    int i;
    i = 0;
    while (!(bus.busy && int'(bus.blockcnt) == blk && int'(bus.cnt) == c)
           && i < budget) begin
      tick(); i++;
    end
    chk("reach_pos", int'(bus.busy && int'(bus.blockcnt) == blk
                                   && int'(bus.cnt) == c), 1);
  endtask

  initial begin
    int exp_cnt;
    int d0;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    repeat (3) tick();
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    rstn = 1'b1;
    repeat (2) tick();

    // Single LCU, no hold.
    clr();
    pulse_start();
    chk("s1_busy", int'(bus.busy), 1);
    chk("s1_blk", int'(bus.blockcnt), 1);
    chk("s1_cnt", int'(bus.cnt), 0);
    chk("s1_cr1", int'(bus.counterrun1), 1);
    chk("s1_cr2", int'(bus.counterrun2), 0);
    wait_done(800);
    chk("s1_latency", t_done - t_run + 1, 657);
    chk("s1_bm8", n8, 16);
    chk("s1_bm16", n16, 4);
    chk("s1_bm32", n32, 1);
    chk("s1_ndone", n_done, 1);
    tick();
    chk("s1_ready", int'(bus.ready), 1);

    // start held high with random hold noise.
    clr();
    bus.start = 1'b1;
    for (int i = 0; i < 2200; i++) begin
      bus.hold = ($urandom_range(0, 9) == 0);
      if (i > 1400) bus.start = ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    wait_ready(1500);
    chk("s2_done_eq_runs", n_done, n_runs);
    chk("s2_multi_runs", int'(n_runs >= 3), 1);

    // Directed 5-cycle hold at block 3, cnt 4.
    clr();
    pulse_start();
    wait_pos(3, 4, 200);
    bus.hold = 1'b1;
    #1;
    chk("s3_cr1_hold", int'(bus.counterrun1), HOLD_EN ? 0 : 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_cnt = HOLD_EN ? 4 : 4 + i;
      chk("s3_cnt_hold", int'(bus.cnt), exp_cnt);
      chk("s3_cr1_hold", int'(bus.counterrun1),
          (!HOLD_EN && exp_cnt < GRAD_LEN) ? 1 : 0);
      chk("s3_cr2_hold", int'(bus.counterrun2),
          (!HOLD_EN && exp_cnt <= GRAD_LEN) ? 1 : 0);
    end
    bus.hold = 1'b0;
    tick();
    chk("s3_resume_cnt", int'(bus.cnt), HOLD_EN ? 5 : 10);
    wait_done(900);
    chk("s3_latency", t_done - t_run + 1, HOLD_EN ? 662 : 657);
    wait_ready(10);

    // Reset in the middle of block 9.
    clr();
    pulse_start();
    wait_pos(9, 20, 700);
    d0 = n_done;
    rstn = 1'b0;
    #1;
    chk("s4_rst_ready", int'(bus.ready), 1);
    chk("s4_rst_outs",
        int'({bus.busy, bus.done, bus.counterrun1, bus.counterrun2,
              bus.bm8_vld, bus.bm16_vld, bus.bm32_vld}), 0);
    chk("s4_rst_cnt", int'(bus.cnt) + int'(bus.blockcnt), 0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (3) tick();
    chk("s4_no_done", n_done, d0);
    pulse_start();
    wait_done(800);
    chk("s4_latency", t_done - t_run + 1, 657);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
